// File: rtl/bcd_entry_decoder.sv
// bcd_entry_decoder
// Collects a two-digit decimal number from the switches, one key press per digit.
// It converts the number to a 4-bit binary value and offers it over valid/ready.
// Out-of-range entries are rejected. The entered digits stay latched so they can
// be echoed on the hex displays.
module bcd_entry_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       enter,
    input  logic       cancel,
    input  logic       value_ready,
    output logic [3:0] value,
    output logic       value_valid,
    output logic       err,
    output logic [3:0] tens_digit,
    output logic [3:0] ones_digit,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_TENS = 2'b00,
        S_ONES = 2'b01,
        S_HOLD = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    state_t     r_state;
    logic       r_enter_q;
    logic [3:0] r_value;
    logic       r_valid;
    logic       r_err;
    logic [3:0] r_tens;
    logic [3:0] r_ones;

    logic       w_press;
    logic [4:0] w_sum;
    logic       w_tens_bad;
    logic       w_ones_bad;

    // A key held for many cycles counts as a single press: only its rising level matters.
    assign w_press = enter & ~r_enter_q;

    // Candidate value: tens*10 + ones. It never exceeds 25, so 5 bits are enough.
    assign w_sum = ({1'b0, r_tens} * 5'd10) + {1'b0, digit_in};

    // The tens digit may only be 0 or 1.
    // The ones digit must be decimal, and the whole number must fit in 4 bits.
    assign w_tens_bad = (digit_in > 4'd1);
    assign w_ones_bad = (digit_in > 4'd9) || (w_sum > 5'd15);

    // Entry sequencer. Cancel beats a transfer, and a transfer beats a key press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_TENS;
            r_enter_q <= 1'b0;
            r_value   <= 4'd0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_tens    <= 4'd0;
            r_ones    <= 4'd0;
        end else begin
            r_enter_q <= enter;
            if (cancel) begin
                r_state <= S_TENS;
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_tens  <= 4'd0;
                r_ones  <= 4'd0;
            end else begin
                case (r_state)
                    S_TENS: begin
                        if (w_press) begin
                            if (w_tens_bad) begin
                                r_err   <= 1'b1;
                                r_state <= S_ERR;
                            end else begin
                                r_tens  <= digit_in;
                                r_state <= S_ONES;
                            end
                        end
                    end
                    S_ONES: begin
                        if (w_press) begin
                            if (w_ones_bad) begin
                                r_err   <= 1'b1;
                                r_state <= S_ERR;
                            end else begin
                                r_ones  <= digit_in;
                                r_value <= w_sum[3:0];
                                r_valid <= 1'b1;
                                r_state <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (value_ready) begin
                            r_valid <= 1'b0;
                            r_state <= S_TENS;
                        end
                    end
                    S_ERR: begin
                        if (w_press) begin
                            r_err   <= 1'b0;
                            r_tens  <= 4'd0;
                            r_ones  <= 4'd0;
                            r_state <= S_TENS;
                        end
                    end
                    default: r_state <= S_TENS;
                endcase
            end
        end
    end

    assign value       = r_value;
    assign value_valid = r_valid;
    assign err         = r_err;
    assign tens_digit  = r_tens;
    assign ones_digit  = r_ones;
    assign state       = r_state;

endmodule

// File: tb/tb_bcd_entry_decoder.sv
// Testbench for bcd_entry_decoder.
// It runs directed vector tables, hand-written multi-cycle sequences and
// randomized cycles checked against an entry-level reference model.
module tb_bcd_entry_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] digitIn = 4'd0;
   logic       enter = 1'b0;
   logic       cancel = 1'b0;
   logic       valueReady = 1'b0;
   logic [3:0] value;
   logic       valueValid;
   logic       err;
   logic [3:0] tensDigit;
   logic [3:0] onesDigit;
   logic [1:0] state;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [3:0] din;
      logic       ent;
      logic       can;
      logic       rdy;
      logic [1:0] st;
      logic [3:0] val;
      logic       vld;
      logic       er;
      logic [3:0] tn;
      logic [3:0] on;
   } vec_t;

   vec_t vecs[$];

   // Reference model state. It tracks the entry in user terms: how many digits are
   // pending, whether a result is waiting, and whether an error needs acknowledging.
   int  mTens, mOnes, mValue, mPending;
   bit  mHolding, mError, mPrevEnter;

   bcd_entry_decoder dut (
      .clk(clk),
      .rst(rst),
      .digit_in(digitIn),
      .enter(enter),
      .cancel(cancel),
      .value_ready(valueReady),
      .value(value),
      .value_valid(valueValid),
      .err(err),
      .tens_digit(tensDigit),
      .ones_digit(onesDigit),
      .state(state)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   function automatic logic [15:0] pack(logic [1:0] st, logic [3:0] val, logic vld, logic er,
                                        logic [3:0] tn, logic [3:0] on);
      return {st, val, vld, er, tn, on};
   endfunction

   task automatic modelReset();
      mTens = 0; mOnes = 0; mValue = 0; mPending = 0;
      mHolding = 0; mError = 0; mPrevEnter = 0;
   endtask

   // One clock edge of the entry as the user experiences it.
   task automatic modelStep(int d, bit e, bit c, bit r);
      bit press;
      int n;
      press = e && !mPrevEnter;
      mPrevEnter = e;
      if (c) begin
         mPending = 0; mHolding = 0; mError = 0; mTens = 0; mOnes = 0;
      end else if (mHolding) begin
         if (r) mHolding = 0;
      end else if (mError) begin
         if (press) begin
            mError = 0; mTens = 0; mOnes = 0;
         end
      end else if (press) begin
         if (mPending == 0) begin
            if (d <= 1) begin
               mTens = d;
               mPending = 1;
            end else begin
               mError = 1;
            end
         end else begin
            n = mTens * 10 + d;
            mPending = 0;
            if (d <= 9 && n <= 15) begin
               mOnes = d;
               mValue = n;
               mHolding = 1;
            end else begin
               mError = 1;
            end
         end
      end
   endtask

   function automatic logic [15:0] modelPack();
      logic [1:0] st;
      st = mError ? 2'd3 : (mHolding ? 2'd2 : (mPending != 0 ? 2'd1 : 2'd0));
      return pack(st, 4'(mValue), mHolding, mError, 4'(mTens), 4'(mOnes));
   endfunction

   // Drive inputs just after an edge, advance the model, then wait for the next edge
   // and settle 1 unit past it before returning.
   task automatic applyStimulus(logic [3:0] d, logic e, logic c, logic r);
      digitIn = d; enter = e; cancel = c; valueReady = r;
      modelStep(int'(d), e, c, r);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(string name, logic [15:0] expected);
      logic [15:0] actual;
      actual = pack(state, value, valueValid, err, tensDigit, onesDigit);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got st=%0d val=%0d vld=%0b err=%0b tens=%0d ones=%0d, want st=%0d val=%0d vld=%0b err=%0b tens=%0d ones=%0d",
                  name, actual[15:14], actual[13:10], actual[9], actual[8], actual[7:4], actual[3:0],
                  expected[15:14], expected[13:10], expected[9], expected[8], expected[7:4], expected[3:0]);
      end
   endtask

   task automatic addVec(logic [3:0] din, logic ent, logic can, logic rdy, logic [1:0] st,
                         logic [3:0] val, logic vld, logic er, logic [3:0] tn, logic [3:0] on);
      vec_t v;
      v.din = din; v.ent = ent; v.can = can; v.rdy = rdy;
      v.st = st; v.val = val; v.vld = vld; v.er = er; v.tn = tn; v.on = on;
      vecs.push_back(v);
   endtask

   initial begin
      logic [3:0] d;
      logic       e, c, r;

      // Valid entry 1,2 -> 12, held for three cycles, then transferred.
      //     din  ent  can  rdy  st  val  vld  err  tens ones
      addVec(4'd1, 1, 0, 0, 2'd1, 4'd0,  0, 0, 4'd1, 4'd0);
      addVec(4'd1, 0, 0, 0, 2'd1, 4'd0,  0, 0, 4'd1, 4'd0);
      addVec(4'd2, 1, 0, 0, 2'd2, 4'd12, 1, 0, 4'd1, 4'd2);
      addVec(4'd2, 0, 0, 0, 2'd2, 4'd12, 1, 0, 4'd1, 4'd2);
      addVec(4'd2, 0, 0, 0, 2'd2, 4'd12, 1, 0, 4'd1, 4'd2);
      addVec(4'd2, 0, 0, 0, 2'd2, 4'd12, 1, 0, 4'd1, 4'd2);
      addVec(4'd2, 0, 0, 1, 2'd0, 4'd12, 0, 0, 4'd1, 4'd2);
      addVec(4'd0, 0, 0, 0, 2'd0, 4'd12, 0, 0, 4'd1, 4'd2);
      // Tens digit 2 is rejected, then acknowledged.
      addVec(4'd2, 1, 0, 0, 2'd3, 4'd12, 0, 1, 4'd1, 4'd2);
      addVec(4'd2, 0, 0, 0, 2'd3, 4'd12, 0, 1, 4'd1, 4'd2);
      addVec(4'd5, 1, 0, 0, 2'd0, 4'd12, 0, 0, 4'd0, 4'd0);
      addVec(4'd5, 0, 0, 0, 2'd0, 4'd12, 0, 0, 4'd0, 4'd0);
      // 1 then 6 makes 16, which is too large.
      addVec(4'd1, 1, 0, 0, 2'd1, 4'd12, 0, 0, 4'd1, 4'd0);
      addVec(4'd1, 0, 0, 0, 2'd1, 4'd12, 0, 0, 4'd1, 4'd0);
      addVec(4'd6, 1, 0, 0, 2'd3, 4'd12, 0, 1, 4'd1, 4'd0);
      addVec(4'd6, 0, 0, 0, 2'd3, 4'd12, 0, 1, 4'd1, 4'd0);
      addVec(4'd0, 1, 0, 0, 2'd0, 4'd12, 0, 0, 4'd0, 4'd0);
      addVec(4'd0, 0, 0, 0, 2'd0, 4'd12, 0, 0, 4'd0, 4'd0);
      // 0 then 10: the ones digit is not decimal.
      addVec(4'd0,  1, 0, 0, 2'd1, 4'd12, 0, 0, 4'd0, 4'd0);
      addVec(4'd0,  0, 0, 0, 2'd1, 4'd12, 0, 0, 4'd0, 4'd0);
      addVec(4'd10, 1, 0, 0, 2'd3, 4'd12, 0, 1, 4'd0, 4'd0);
      addVec(4'd10, 0, 0, 0, 2'd3, 4'd12, 0, 1, 4'd0, 4'd0);
      addVec(4'd10, 1, 0, 0, 2'd0, 4'd12, 0, 0, 4'd0, 4'd0);
      addVec(4'd10, 0, 0, 0, 2'd0, 4'd12, 0, 0, 4'd0, 4'd0);
      // 15 is the largest accepted value. Presses while holding are ignored.
      addVec(4'd1, 1, 0, 0, 2'd1, 4'd12, 0, 0, 4'd1, 4'd0);
      addVec(4'd1, 0, 0, 0, 2'd1, 4'd12, 0, 0, 4'd1, 4'd0);
      addVec(4'd5, 1, 0, 0, 2'd2, 4'd15, 1, 0, 4'd1, 4'd5);
      addVec(4'd5, 0, 0, 0, 2'd2, 4'd15, 1, 0, 4'd1, 4'd5);
      addVec(4'd3, 1, 0, 0, 2'd2, 4'd15, 1, 0, 4'd1, 4'd5);
      addVec(4'd3, 0, 0, 0, 2'd2, 4'd15, 1, 0, 4'd1, 4'd5);
      // Cancel together with ready in HOLD; cancel together with a press in TENS.
      addVec(4'd3, 0, 1, 1, 2'd0, 4'd15, 0, 0, 4'd0, 4'd0);
      addVec(4'd1, 0, 0, 0, 2'd0, 4'd15, 0, 0, 4'd0, 4'd0);
      addVec(4'd1, 1, 1, 0, 2'd0, 4'd15, 0, 0, 4'd0, 4'd0);
      addVec(4'd1, 0, 0, 0, 2'd0, 4'd15, 0, 0, 4'd0, 4'd0);
      // Cancel in HOLD without ready keeps the value 12.
      addVec(4'd1, 1, 0, 0, 2'd1, 4'd15, 0, 0, 4'd1, 4'd0);
      addVec(4'd1, 0, 0, 0, 2'd1, 4'd15, 0, 0, 4'd1, 4'd0);
      addVec(4'd2, 1, 0, 0, 2'd2, 4'd12, 1, 0, 4'd1, 4'd2);
      addVec(4'd2, 0, 0, 0, 2'd2, 4'd12, 1, 0, 4'd1, 4'd2);
      addVec(4'd2, 0, 1, 0, 2'd0, 4'd12, 0, 0, 4'd0, 4'd0);
      // 0 then 9 is accepted, and the digits survive the transfer.
      addVec(4'd0, 1, 0, 0, 2'd1, 4'd12, 0, 0, 4'd0, 4'd0);
      addVec(4'd0, 0, 0, 0, 2'd1, 4'd12, 0, 0, 4'd0, 4'd0);
      addVec(4'd9, 1, 0, 0, 2'd2, 4'd9,  1, 0, 4'd0, 4'd9);
      addVec(4'd9, 0, 0, 1, 2'd0, 4'd9,  0, 0, 4'd0, 4'd9);

      // Reset state after five idle cycles.
      modelReset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset", 16'h0000);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].din, vecs[i].ent, vecs[i].can, vecs[i].rdy);
         checkOutput($sformatf("vec%0d", i),
                     pack(vecs[i].st, vecs[i].val, vecs[i].vld, vecs[i].er, vecs[i].tn, vecs[i].on));
      end

      // A key held for 20 cycles advances only one step.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
         checkOutput("heldEnter", pack(2'd1, 4'd9, 1'b0, 1'b0, 4'd0, 4'd9));
      end
      applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("cancelOnes", pack(2'd0, 4'd9, 1'b0, 1'b0, 4'd0, 4'd0));
      applyStimulus(4'd1, 1'b1, 1'b0, 1'b0);
      checkOutput("preResetOnes", pack(2'd1, 4'd9, 1'b0, 1'b0, 4'd1, 4'd0));

      // Asynchronous reset pulsed between edges while in ONES.
      #2 rst = 1'b1;
      #1 checkOutput("asyncResetDuring", 16'h0000);
      #1 rst = 1'b0;
      #1 checkOutput("asyncResetAfter", 16'h0000);
      enter = 1'b0;
      @(posedge clk);
      #1;

      // Randomized cycles against the reference model.
      rst = 1'b1;
      modelReset();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 1) == 0) d = 4'($urandom_range(0, 1));
         else d = 4'($urandom_range(0, 15));
         e = ($urandom_range(0, 1) == 0);
         c = ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 2) == 0);
         applyStimulus(d, e, c, r);
         checkOutput("random", modelPack());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
